// File: rtl/mem_responder.sv
`default_nettype none
//============================================================================
// Module   : mem_responder
// Brief    : Memory-side responder for a four-channel valid/ack CPU memory
//            interface (instruction request/response, data request/response).
//            One word-organised array is shared by the instruction and data
//            FSMs. Each access has a programmable wait latency, and the data
//            side wins when both sides reach the array port in the same cycle.
// Options  : MEM_PERF_CNT_EN - when defined, adds four 32-bit performance
//            counters. When undefined, mem_perf_cnt_* are tied to zero.
// Revision : 1.0 - initial release
//============================================================================
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        rst,
    // instruction request / response
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ack,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ack,
    // data request / response
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ack,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ack,
    // performance counters
    output logic [31:0] mem_perf_cnt_0,
    output logic [31:0] mem_perf_cnt_1,
    output logic [31:0] mem_perf_cnt_2,
    output logic [31:0] mem_perf_cnt_3
);

    localparam int         c_DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [3:0] c_LAT   = 4'(LATENCY);

    localparam logic [1:0] c_I_IDLE = 2'd0;
    localparam logic [1:0] c_I_ACK  = 2'd1;
    localparam logic [1:0] c_I_WAIT = 2'd2;
    localparam logic [1:0] c_I_RESP = 2'd3;

    localparam logic [1:0] c_D_IDLE = 2'd0;
    localparam logic [1:0] c_D_ACK  = 2'd1;
    localparam logic [1:0] c_D_WAIT = 2'd2;
    localparam logic [1:0] c_D_RESP = 2'd3;

    logic [31:0]           r_mem [c_DEPTH];

    logic [1:0]            r_i_state;
    logic [3:0]            r_i_cnt;
    logic [ADDR_WIDTH-1:0] r_i_idx;

    logic [1:0]            r_d_state;
    logic [3:0]            r_d_cnt;
    logic [ADDR_WIDTH-1:0] r_d_idx;
    logic [31:0]           r_d_wdata;
    logic [3:0]            r_d_strb;
    logic                  r_d_write;

    logic                  w_d_access;
    logic                  w_i_want;
    logic                  w_i_access;
    logic                  w_mem_we;
    logic                  w_unused_bits;

    // Single array port: the data side takes it whenever it is ready, and the
    // instruction side only gets it in cycles the data side leaves free.
    assign w_d_access = (r_d_state == c_D_WAIT) && (r_d_cnt == 4'd0);
    assign w_i_want   = (r_i_state == c_I_WAIT) && (r_i_cnt == 4'd0);
    assign w_i_access = w_i_want && !w_d_access;
    // A store caught by reset in its access cycle must not reach the array.
    assign w_mem_we   = w_d_access && r_d_write && rst;

    // Only the word-index bits of each address select a word; the rest alias.
    assign w_unused_bits = ^{PC[31:ADDR_WIDTH+2], PC[1:0],
                             Address[31:ADDR_WIDTH+2], Address[1:0]};

    // Instruction FSM: accept fetch, wait LATENCY cycles, read array, hold response.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_i_state    <= c_I_IDLE;
            r_i_cnt      <= 4'd0;
            r_i_idx      <= '0;
            Inst_Req_Ack <= 1'b0;
            Inst_Valid   <= 1'b0;
            Instruction  <= 32'd0;
        end else begin
            Inst_Req_Ack <= 1'b0;
            case (r_i_state)
                c_I_IDLE: begin
                    if (Inst_Req_Valid) begin
                        r_i_idx      <= PC[ADDR_WIDTH+1:2];
                        Inst_Req_Ack <= 1'b1;
                        r_i_state    <= c_I_ACK;
                    end
                end
                c_I_ACK: begin
                    r_i_cnt   <= c_LAT;
                    r_i_state <= c_I_WAIT;
                end
                c_I_WAIT: begin
                    if (r_i_cnt != 4'd0) begin
                        r_i_cnt <= r_i_cnt - 4'd1;
                    end else if (w_i_access) begin
                        Instruction <= r_mem[r_i_idx];
                        Inst_Valid  <= 1'b1;
                        r_i_state   <= c_I_RESP;
                    end
                end
                c_I_RESP: begin
                    if (Inst_Ack) begin
                        Inst_Valid <= 1'b0;
                        r_i_state  <= c_I_IDLE;
                    end
                end
                default: r_i_state <= c_I_IDLE;
            endcase
        end
    end

    // Data FSM: accept load/store (store wins if both), wait, access, respond on loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_d_state       <= c_D_IDLE;
            r_d_cnt         <= 4'd0;
            r_d_idx         <= '0;
            r_d_wdata       <= 32'd0;
            r_d_strb        <= 4'd0;
            r_d_write       <= 1'b0;
            Mem_Req_Ack     <= 1'b0;
            Read_data_Valid <= 1'b0;
            Read_data       <= 32'd0;
        end else begin
            Mem_Req_Ack <= 1'b0;
            case (r_d_state)
                c_D_IDLE: begin
                    if (MemWrite || MemRead) begin
                        r_d_idx     <= Address[ADDR_WIDTH+1:2];
                        r_d_wdata   <= Write_data;
                        r_d_strb    <= Write_strb;
                        r_d_write   <= MemWrite;
                        Mem_Req_Ack <= 1'b1;
                        r_d_state   <= c_D_ACK;
                    end
                end
                c_D_ACK: begin
                    r_d_cnt   <= c_LAT;
                    r_d_state <= c_D_WAIT;
                end
                c_D_WAIT: begin
                    if (r_d_cnt != 4'd0) begin
                        r_d_cnt <= r_d_cnt - 4'd1;
                    end else if (r_d_write) begin
                        r_d_state <= c_D_IDLE;
                    end else begin
                        Read_data       <= r_mem[r_d_idx];
                        Read_data_Valid <= 1'b1;
                        r_d_state       <= c_D_RESP;
                    end
                end
                c_D_RESP: begin
                    if (Read_data_Ack) begin
                        Read_data_Valid <= 1'b0;
                        r_d_state       <= c_D_IDLE;
                    end
                end
                default: r_d_state <= c_D_IDLE;
            endcase
        end
    end

    // Byte-masked array write; contents are not touched by reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (r_d_strb[b]) begin
                    r_mem[r_d_idx][8*b +: 8] <= r_d_wdata[8*b +: 8];
                end
            end
        end
    end

`ifdef MEM_PERF_CNT_EN
    logic [31:0] r_perf_fetch;
    logic [31:0] r_perf_load;
    logic [31:0] r_perf_store;
    logic [31:0] r_perf_stall;

    // Wrapping event counters: completed fetches/loads, stores, arbitration stalls.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_fetch <= 32'd0;
            r_perf_load  <= 32'd0;
            r_perf_store <= 32'd0;
            r_perf_stall <= 32'd0;
        end else begin
            if (Inst_Valid && Inst_Ack)          r_perf_fetch <= r_perf_fetch + 32'd1;
            if (Read_data_Valid && Read_data_Ack) r_perf_load  <= r_perf_load + 32'd1;
            if (w_mem_we)                         r_perf_store <= r_perf_store + 32'd1;
            if (w_i_want && w_d_access)           r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign mem_perf_cnt_0 = r_perf_fetch;
    assign mem_perf_cnt_1 = r_perf_load;
    assign mem_perf_cnt_2 = r_perf_store;
    assign mem_perf_cnt_3 = r_perf_stall;
`else
    assign mem_perf_cnt_0 = 32'd0;
    assign mem_perf_cnt_1 = 32'd0;
    assign mem_perf_cnt_2 = 32'd0;
    assign mem_perf_cnt_3 = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
//============================================================================
// Module   : tb_mem_responder
// Brief    : Self-checking bench for mem_responder: directed scenarios then
//            randomized single transactions checked against a word-array
//            reference model with byte-strobe merging and fixed latency.
// Options  : MEM_PERF_CNT_EN - when defined, checks the performance counters
//            against the model; otherwise requires them to be zero.
// Revision : 1.0 - initial release
//============================================================================
module tb_mem_responder;

    localparam int AW    = 10;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << AW;

    logic        clk;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ack;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ack;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ack;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ack;
    logic [31:0] mem_perf_cnt_0;
    logic [31:0] mem_perf_cnt_1;
    logic [31:0] mem_perf_cnt_2;
    logic [31:0] mem_perf_cnt_3;

    mem_responder #(.ADDR_WIDTH(AW), .LATENCY(LAT)) dut (
        .clk             (clk),
        .rst             (rst),
        .PC              (PC),
        .Inst_Req_Valid  (Inst_Req_Valid),
        .Inst_Req_Ack    (Inst_Req_Ack),
        .Instruction     (Instruction),
        .Inst_Valid      (Inst_Valid),
        .Inst_Ack        (Inst_Ack),
        .Address         (Address),
        .MemWrite        (MemWrite),
        .Write_data      (Write_data),
        .Write_strb      (Write_strb),
        .MemRead         (MemRead),
        .Mem_Req_Ack     (Mem_Req_Ack),
        .Read_data       (Read_data),
        .Read_data_Valid (Read_data_Valid),
        .Read_data_Ack   (Read_data_Ack),
        .mem_perf_cnt_0  (mem_perf_cnt_0),
        .mem_perf_cnt_1  (mem_perf_cnt_1),
        .mem_perf_cnt_2  (mem_perf_cnt_2),
        .mem_perf_cnt_3  (mem_perf_cnt_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // reference model
    logic [31:0] model_mem [int];
    int pf_fetch = 0;
    int pf_load  = 0;
    int pf_store = 0;
    int pf_conf  = 0;

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % 32'(DEPTH));
    endfunction

    function automatic logic [31:0] model_rd(input logic [31:0] a);
        return model_mem[widx(a)];
    endfunction

    task automatic model_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] w;
        w = model_mem[widx(a)];
        for (int b = 0; b < 4; b++)
            if (s[b]) w[8*b +: 8] = d[8*b +: 8];
        model_mem[widx(a)] = w;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_perf(input string tag);
`ifdef MEM_PERF_CNT_EN
        check({tag, "_fetch"}, mem_perf_cnt_0, 32'(pf_fetch));
        check({tag, "_load"},  mem_perf_cnt_1, 32'(pf_load));
        check({tag, "_store"}, mem_perf_cnt_2, 32'(pf_store));
        check({tag, "_stall"}, mem_perf_cnt_3, 32'(pf_conf));
`else
        check({tag, "_fetch"}, mem_perf_cnt_0, 32'd0);
        check({tag, "_load"},  mem_perf_cnt_1, 32'd0);
        check({tag, "_store"}, mem_perf_cnt_2, 32'd0);
        check({tag, "_stall"}, mem_perf_cnt_3, 32'd0);
`endif
    endtask

    task automatic do_fetch(input logic [31:0] pc, input int hold);
        logic [31:0] exp;
        int n;
        exp = model_rd(pc);
        PC = pc; Inst_Req_Valid = 1'b1;
        tick; n = 1;
        check("fetch_req_ack", 32'(Inst_Req_Ack), 32'd1);
        Inst_Req_Valid = 1'b0; PC = $urandom;
        while (!Inst_Valid && n < 60) begin
            tick; n++;
            if (n == 2) check("fetch_ack_pulse", 32'(Inst_Req_Ack), 32'd0);
        end
        check("fetch_latency", 32'(n), 32'(LAT + 3));
        check("fetch_data", Instruction, exp);
        for (int k = 0; k < hold; k++) begin
            tick;
            check("fetch_hold", {Instruction[30:0], Inst_Valid}, {exp[30:0], 1'b1});
        end
        Inst_Ack = 1'b1;
        tick;
        Inst_Ack = 1'b0; pf_fetch++;
        check("fetch_release", 32'(Inst_Valid), 32'd0);
    endtask

    task automatic do_load(input logic [31:0] a, input int hold);
        logic [31:0] exp;
        int n;
        exp = model_rd(a);
        Address = a; MemRead = 1'b1;
        tick; n = 1;
        check("load_req_ack", 32'(Mem_Req_Ack), 32'd1);
        MemRead = 1'b0; Address = $urandom;
        while (!Read_data_Valid && n < 60) begin
            tick; n++;
            if (n == 2) check("load_ack_pulse", 32'(Mem_Req_Ack), 32'd0);
        end
        check("load_latency", 32'(n), 32'(LAT + 3));
        check("load_data", Read_data, exp);
        for (int k = 0; k < hold; k++) begin
            tick;
            check("load_hold_valid", 32'(Read_data_Valid), 32'd1);
            check("load_hold_data", Read_data, exp);
        end
        Read_data_Ack = 1'b1;
        tick;
        Read_data_Ack = 1'b0; pf_load++;
        check("load_release", 32'(Read_data_Valid), 32'd0);
    endtask

    // both=1 raises MemRead together with MemWrite; it must behave as a store
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic both);
        int n;
        int quiet;
        Address = a; Write_data = d; Write_strb = s; MemWrite = 1'b1; MemRead = both;
        tick; n = 1;
        check("store_req_ack", 32'(Mem_Req_Ack), 32'd1);
        MemWrite = 1'b0; MemRead = 1'b0;
        Address = $urandom; Write_data = $urandom; Write_strb = 4'($urandom);
        quiet = both ? LAT + 6 : LAT + 3;
        while (n < quiet) begin
            tick; n++;
            check("store_quiet", {30'd0, Mem_Req_Ack, Read_data_Valid}, 32'd0);
        end
        model_wr(a, d, s);
        pf_store++;
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        int n, dn, in_n, w;

        rst = 1'b0; PC = 32'd0; Inst_Req_Valid = 1'b0; Inst_Ack = 1'b0;
        Address = 32'd0; MemWrite = 1'b0; Write_data = 32'd0; Write_strb = 4'd0;
        MemRead = 1'b0; Read_data_Ack = 1'b0;
        repeat (3) tick;

        // reset state
        check("rst_inst_req_ack", 32'(Inst_Req_Ack), 32'd0);
        check("rst_inst_valid", 32'(Inst_Valid), 32'd0);
        check("rst_instruction", Instruction, 32'd0);
        check("rst_mem_req_ack", 32'(Mem_Req_Ack), 32'd0);
        check("rst_rd_valid", 32'(Read_data_Valid), 32'd0);
        check("rst_read_data", Read_data, 32'd0);
        check_perf("rst_perf");
        rst = 1'b1;
        tick;

        // preload words 0..15 through the store path
        for (int i = 0; i < 16; i++) begin
            v = (i == 4) ? 32'h2402_0005 : (i == 8) ? 32'd0 : $urandom;
            do_store(32'(i) << 2, v, 4'hF, 1'b0);
        end

        // basic fetch with a held response
        do_fetch(32'h10, 2);

        // partial-strobe store then held load
        do_store(32'h20, 32'hAABB_CCDD, 4'b0101, 1'b0);
        check("strb_model", model_rd(32'h20), 32'h00BB_00DD);
        do_load(32'h20, 3);

        // fetch and load issued together: data first, fetch one cycle later
        PC = 32'h10; Inst_Req_Valid = 1'b1; Address = 32'h20; MemRead = 1'b1;
        tick; n = 1; dn = 0; in_n = 0;
        check("both_acks", {30'd0, Inst_Req_Ack, Mem_Req_Ack}, 32'd3);
        Inst_Req_Valid = 1'b0; MemRead = 1'b0;
        while ((dn == 0 || in_n == 0) && n < 60) begin
            tick; n++;
            if (Read_data_Valid && dn == 0) dn = n;
            if (Inst_Valid && in_n == 0) in_n = n;
        end
        check("conflict_data_lat", 32'(dn), 32'(LAT + 3));
        check("conflict_inst_lat", 32'(in_n), 32'(LAT + 4));
        check("conflict_rdata", Read_data, 32'h00BB_00DD);
        check("conflict_inst", Instruction, 32'h2402_0005);
        Inst_Ack = 1'b1; Read_data_Ack = 1'b1;
        tick;
        Inst_Ack = 1'b0; Read_data_Ack = 1'b0;
        pf_fetch++; pf_load++; pf_conf++;
        check_perf("conflict_perf");

        // address aliasing modulo depth
        do_store(32'h1000, 32'hCAFE_F00D, 4'hF, 1'b0);
        do_load(32'h3, 0);
        check("alias_model", model_rd(32'h0), 32'hCAFE_F00D);

        // read and write together behaves as a store only
        do_store(32'h24, 32'h1357_9BDF, 4'hF, 1'b1);
        do_load(32'h24, 1);

        // store then fetch of the same word, and an all-zero strobe store
        do_store(32'h14, 32'h0BAD_BEEF, 4'hF, 1'b0);
        do_fetch(32'h14, 0);
        do_store(32'h14, 32'hFFFF_FFFF, 4'h0, 1'b0);
        do_load(32'h14, 0);

        // reset while a store waits: store is dropped, all outputs clear
        PC = 32'h10; Inst_Req_Valid = 1'b1;
        tick; Inst_Req_Valid = 1'b0; n = 1;
        while (!Inst_Valid && n < 60) begin tick; n++; end
        check("rst_pre_fetch_valid", 32'(Inst_Valid), 32'd1);
        Address = 32'h24; Write_data = 32'h5555_AAAA; Write_strb = 4'hF; MemWrite = 1'b1;
        tick; MemWrite = 1'b0;
        tick;
        rst = 1'b0;
        tick;
        check("mid_rst_inst_valid", 32'(Inst_Valid), 32'd0);
        check("mid_rst_instruction", Instruction, 32'd0);
        check("mid_rst_acks", {30'd0, Inst_Req_Ack, Mem_Req_Ack}, 32'd0);
        check("mid_rst_rd_valid", 32'(Read_data_Valid), 32'd0);
        check("mid_rst_read_data", Read_data, 32'd0);
        pf_fetch = 0; pf_load = 0; pf_store = 0; pf_conf = 0;
        check_perf("mid_rst_perf");
        rst = 1'b1;
        tick;
        do_load(32'h24, 0);
        do_fetch(32'h10, 1);

        // randomized single transactions against the model
        for (int it = 0; it < 40; it++) begin
            w = int'($urandom_range(0, 15));
            a = (32'($urandom_range(0, 3)) << (AW + 2)) | (32'(w) << 2) | 32'($urandom_range(0, 3));
            case ($urandom_range(0, 2))
                0:       do_store(a, $urandom, 4'($urandom_range(0, 15)), 1'b0);
                1:       do_load(a, int'($urandom_range(0, 3)));
                default: do_fetch(a, int'($urandom_range(0, 3)));
            endcase
        end
        tick;
        check_perf("final_perf");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
